tape_ctrl: RTL

Controller for the tape buffer that feeds the `cassette` player. It owns the single-port tape RAM and shares it between the loader (ioctl download) and the player's read port. It records the loaded tape length as `tape_end`, sequences the transport (`cas_en`, `cas_rewind`) from the debounced motor relay and the user rewind request, and blocks playback while a tape is loading.

---
 rtl/tape_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tape_ctrl.sv
// Tape buffer controller: arbitrates the single-port tape RAM between the loader and the
// cassette player, records the loaded length and sequences the tape transport.
module tape_ctrl #(
  parameter int AW     = 16,
  parameter int RD_LAT = 1,
  parameter int DEB    = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [AW-1:0] play_addr,
  output logic [7:0]    play_data,
  output logic          play_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          motor,
  input  logic          rewind_req,
  output logic [AW-1:0] tape_end,
  output logic          tape_loaded,
  output logic          cas_en,
  output logic          cas_rewind
);

  localparam int DCW = $clog2(DEB + 1);
  localparam int RCW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOADING,
    S_STOPPED,
    S_PLAYING
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_motor_s1;
  logic            r_motor_s2;
  logic            r_motor_f;
  logic [DCW-1:0]  r_deb_cnt;
  logic            r_dl_q;
  logic            r_any_wr;
  logic [AW-1:0]   r_tape_end;
  logic            r_wr_pend;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data;
  logic [AW-1:0]   r_play_addr_q;
  logic [RCW-1:0]  r_rd_cnt;
  logic            r_cas_en;
  logic            r_cas_rewind;
  logic            w_dl_rise;
  logic            w_dl_fall;
  logic            w_wr_acc;
  logic            w_loaded;
  logic            w_load_done;
  logic            w_rew_tgl;
  logic            w_addr_chg;

  assign w_dl_rise  = ioctl_download & ~r_dl_q;
  assign w_dl_fall  = ~ioctl_download & r_dl_q;
  assign w_wr_acc   = ioctl_wr && (r_state == S_LOADING);
  assign w_loaded   = (r_state == S_STOPPED) || (r_state == S_PLAYING);
  assign w_addr_chg = (play_addr != r_play_addr_q);
  assign w_rew_tgl  = w_load_done | (rewind_req & w_loaded);

  // Motor relay: two-flop synchronizer, then the filtered level only follows after DEB equal samples.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_motor_s1 <= 1'b0;
      r_motor_s2 <= 1'b0;
      r_motor_f  <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_motor_s1 <= motor;
      r_motor_s2 <= r_motor_s1;
      if (r_motor_s2 == r_motor_f) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DCW'(DEB - 1)) begin
        r_motor_f <= r_motor_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DCW'(1);
      end
    end
  end

  // NOTE: defaults come first so every path assigns each signal and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load_done = 1'b0;
    if (w_dl_rise) begin
      w_state_nxt = S_LOADING;
    end else begin
      case (r_state)
        S_LOADING: begin
          if (w_dl_fall) begin
            if (r_any_wr || w_wr_acc) begin
              w_state_nxt = S_STOPPED;
              w_load_done = 1'b1;
            end else begin
              w_state_nxt = S_EMPTY;
            end
          end
        end
        S_STOPPED: if (r_motor_f)  w_state_nxt = S_PLAYING;
        S_PLAYING: if (!r_motor_f) w_state_nxt = S_STOPPED;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_EMPTY;
      r_cas_en     <= 1'b0;
      r_cas_rewind <= 1'b0;
      r_dl_q       <= 1'b0;
      r_any_wr     <= 1'b0;
      r_tape_end   <= '0;
      r_wr_pend    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cas_en <= (w_state_nxt == S_PLAYING);
      r_dl_q   <= ioctl_download;
      if (w_rew_tgl) r_cas_rewind <= ~r_cas_rewind;
      if (w_dl_rise) begin
        r_tape_end <= '0;
        r_any_wr   <= 1'b0;
      end else if (w_wr_acc) begin
        r_any_wr <= 1'b1;
        if (ioctl_addr > r_tape_end) r_tape_end <= ioctl_addr;
      end
      r_wr_pend <= w_wr_acc;
      if (w_wr_acc) begin
        r_wr_addr <= ioctl_addr;
        r_wr_data <= ioctl_dout;
      end
    end
  end

  // r_rd_cnt counts consecutive edges at which the RAM sampled the current play_addr as a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_play_addr_q <= '0;
      r_rd_cnt      <= '0;
    end else begin
      r_play_addr_q <= play_addr;
      if (r_wr_pend) begin
        r_rd_cnt <= '0;
      end else if (w_addr_chg) begin
        r_rd_cnt <= RCW'(1);
      end else if (r_rd_cnt != RCW'(RD_LAT)) begin
        r_rd_cnt <= r_rd_cnt + RCW'(1);
      end
    end
  end

  assign mem_we      = r_wr_pend;
  assign mem_addr    = r_wr_pend ? r_wr_addr : play_addr;
  assign mem_din     = r_wr_data;
  assign play_data   = mem_dout;
  assign play_valid  = (r_rd_cnt == RCW'(RD_LAT)) && !w_addr_chg && w_loaded;
  assign tape_end    = r_tape_end;
  assign tape_loaded = w_loaded;
  assign cas_en      = r_cas_en;
  assign cas_rewind  = r_cas_rewind;

endmodule
